obi_window_fetcher: RTL and testbench

//  OBI manager that fetches the 8 neighbour pixels of a 3x3 Sobel window around one centre pixel from SRAM.
//  It sequences 8 single-byte OBI read transactions and delivers the packed window on a valid/ready port.
//  It sits in the user domain between the Sobel datapath (consumer) and the SRAM0 OBI crossbar port.

---
 rtl/obi_pkg.sv | 39 +++
 rtl/sobel_pkg.sv | 37 +++
 rtl/obi_window_fetcher.sv | 126 ++++++++++++
 tb/tb_obi_window_fetcher.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// Minimal OBI type definitions used by the window fetcher.
// Provides the configuration record and the default request/response structs.
// Optional OBI fields not used by this design are omitted.
package obi_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

// File: rtl/sobel_pkg.sv
// Shared Sobel types: pixel/window types, fetch FSM states and the
// neighbour address generator used by the window fetcher.
package sobel_pkg;

    localparam int unsigned AddrWidth     = obi_pkg::ObiDefaultConfig.AddrWidth;
    localparam int unsigned NumNeighbours = 8;

    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [7:0]           pixel_t;
    typedef pixel_t [NumNeighbours-1:0] window_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } fetch_state_e;

    // Byte address of neighbour k around the centre pixel, in raster order
    // (row above, same row without the centre, row below). Modulo arithmetic.
    function automatic addr_t nb_addr(input addr_t base, input addr_t stride, input logic [2:0] k);
        addr_t row;
        addr_t nb;
        case (k)
            3'd0, 3'd1, 3'd2: row = base - stride;
            3'd3, 3'd4:       row = base;
            default:          row = base + stride;
        endcase
        case (k)
            3'd0, 3'd3, 3'd5: nb = row - addr_t'(1);
            3'd1, 3'd6:       nb = row;
            default:          nb = row + addr_t'(1);
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/obi_window_fetcher.sv
// OBI manager fetching the 8 neighbours of a 3x3 window around a centre pixel.
// Issues 8 single-byte reads, one outstanding at a time, and presents the
// packed window on a valid/ready port.
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   start_i                  begin a fetch (only honoured in IDLE)
//   base_addr_i, stride_i    centre pixel byte address, row stride in bytes
//   busy_o                   high whenever not IDLE
//   win_valid_o/win_ready_i  window handshake
//   win_o                    p[k] = win_o[8k+:8]
//   err_o                    OR of read error responses, valid with win_valid_o
//   obi_req_o/obi_rsp_i      OBI manager port
module obi_window_fetcher
    import sobel_pkg::*;
#(
    parameter obi_pkg::obi_cfg_t ObiCfg = obi_pkg::ObiDefaultConfig,
    parameter type obi_req_t = obi_pkg::obi_req_t,
    parameter type obi_rsp_t = obi_pkg::obi_rsp_t
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic [ObiCfg.AddrWidth-1:0] base_addr_i,
    input  logic [ObiCfg.AddrWidth-1:0] stride_i,
    output logic                        busy_o,
    output logic                        win_valid_o,
    input  logic                        win_ready_i,
    output logic [63:0]                 win_o,
    output logic                        err_o,
    output obi_req_t                    obi_req_o,
    input  obi_rsp_t                    obi_rsp_i
);

    fetch_state_e state_q, state_d;
    logic [2:0]   idx_q;
    addr_t        base_q;
    addr_t        stride_q;
    window_t      win_q;
    logic         err_q;
    addr_t        pix_addr;
    logic [1:0]   lane;
    logic         unused_rsp;

    // base/stride/idx are stable across REQ and RESP, so the same address
    // drives the request and selects the byte lane of the response.
    assign pix_addr   = nb_addr(base_q, stride_q, idx_q);
    assign lane       = pix_addr[1:0];
    assign unused_rsp = ^obi_rsp_i.r.rid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        obi_req_o   = '0;
        busy_o      = 1'b1;
        win_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_d = REQ;
            end
            REQ: begin
                obi_req_o.req    = 1'b1;
                obi_req_o.a.addr = pix_addr & ~addr_t'(3);
                obi_req_o.a.be   = 4'b0001 << lane;
                if (obi_rsp_i.gnt) state_d = RESP;
            end
            RESP: begin
                if (obi_rsp_i.rvalid) begin
                    state_d = (idx_q == 3'd7) ? DONE : REQ;
                end
            end
            DONE: begin
                win_valid_o = 1'b1;
                if (win_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the 8-byte window storage is reset along with the control state
    // because win_o must read as zero after reset; it is small enough to be
    // plain flops rather than a RAM macro.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idx_q    <= '0;
            base_q   <= '0;
            stride_q <= '0;
            win_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        base_q   <= base_addr_i;
                        stride_q <= stride_i;
                        idx_q    <= '0;
                        err_q    <= 1'b0;
                    end
                end
                RESP: begin
                    if (obi_rsp_i.rvalid) begin
                        win_q[idx_q] <= obi_rsp_i.r.rdata[{lane, 3'b000} +: 8];
                        err_q        <= err_q | obi_rsp_i.r.err;
                        if (idx_q != 3'd7) idx_q <= idx_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign win_o = win_q;
    assign err_o = err_q;

endmodule

// File: tb/tb_obi_window_fetcher.sv
module tb_obi_window_fetcher;
    import obi_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [31:0] stride_i;
    logic        busy_o;
    logic        win_valid_o;
    logic        win_ready_i;
    logic [63:0] win_o;
    logic        err_o;
    obi_req_t    obi_req_o;
    obi_rsp_t    obi_rsp_i;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    obi_window_fetcher dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .stride_i    (stride_i),
        .busy_o      (busy_o),
        .win_valid_o (win_valid_o),
        .win_ready_i (win_ready_i),
        .win_o       (win_o),
        .err_o       (err_o),
        .obi_req_o   (obi_req_o),
        .obi_rsp_i   (obi_rsp_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] base;
        logic [31:0] stride;
        int          gd;
        int          rd;
        int          ek;
        logic [63:0] exp_win;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] first_pix;
        logic [31:0] last_pix;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc_n++;
    endtask

    // Memory contents: mode 0 returns the low address byte, mode 1 a hash.
    function automatic logic [7:0] mem_byte(input int mode, input logic [31:0] a);
        if (mode == 0) return a[7:0];
        return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] mem_word(input int mode, input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = mem_byte(mode, (a & ~32'h3) + 32'(i));
        return w;
    endfunction

    // Neighbour k = centre + row offset * stride + column offset.
    function automatic logic [31:0] model_pix(input logic [31:0] base, input logic [31:0] stride, input int k);
        int dr [8];
        int dc [8];
        dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
        dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
        return base + stride * 32'(dr[k]) + 32'(dc[k]);
    endfunction

    function automatic logic [63:0] model_win(input logic [31:0] base, input logic [31:0] stride, input int mode);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = mem_byte(mode, model_pix(base, stride, k));
        return w;
    endfunction

    task automatic serve_read(input int k, input int gd, input int rd, input int ek, input int mode,
                              input logic [31:0] exp_pix, output logic [31:0] a, output logic [3:0] be);
        int waited = 0;
        while (!obi_req_o.req && waited < 20) begin
            tick();
            waited++;
        end
        check("req_seen", obi_req_o.req, 1'b1);
        a  = obi_req_o.a.addr;
        be = obi_req_o.a.be;
        check("addr", a, exp_pix & ~32'h3);
        check("be", be, 4'b0001 << exp_pix[1:0]);
        check("we", obi_req_o.a.we, 1'b0);
        repeat (gd) begin
            tick();
            check("req_hold", {obi_req_o.req, obi_req_o.a.addr, obi_req_o.a.be}, {1'b1, a, be});
        end
        obi_rsp_i.gnt = 1'b1;
        tick();
        obi_rsp_i.gnt = 1'b0;
        check("req_drop", obi_req_o.req, 1'b0);
        repeat (rd) tick();
        obi_rsp_i.rvalid  = 1'b1;
        obi_rsp_i.r.rdata = mem_word(mode, a);
        obi_rsp_i.r.err   = (k == ek);
        tick();
        obi_rsp_i.rvalid  = 1'b0;
        obi_rsp_i.r.err   = 1'b0;
        obi_rsp_i.r.rdata = '0;
    endtask

    // Runs one fetch from start up to DONE; leaves the window unacknowledged.
    task automatic run_window(input logic [31:0] base, input logic [31:0] stride, input int gd, input int rd,
                              input int ek, input int mode, output int cyc,
                              output logic [31:0] a0, output logic [3:0] be0,
                              output logic [31:0] a7, output logic [3:0] be7);
        int t0;
        int waited = 0;
        logic [31:0] a;
        logic [3:0]  be;
        start_i     = 1'b1;
        base_addr_i = base;
        stride_i    = stride;
        t0          = cyc_n;
        tick();
        start_i     = 1'b0;
        base_addr_i = $urandom;
        stride_i    = $urandom;
        check("err_clr_on_start", err_o, 1'b0);
        check("busy_on_start", busy_o, 1'b1);
        a0 = '0; be0 = '0; a7 = '0; be7 = '0;
        for (int k = 0; k < 8; k++) begin
            serve_read(k, gd, rd, ek, mode, model_pix(base, stride, k), a, be);
            if (k == 0) begin a0 = a; be0 = be; end
            if (k == 7) begin a7 = a; be7 = be; end
        end
        while (!win_valid_o && waited < 20) begin
            tick();
            waited++;
        end
        check("valid_seen", win_valid_o, 1'b1);
        cyc = cyc_n - t0;
    endtask

    task automatic ack(input logic [63:0] w);
        win_ready_i = 1'b1;
        tick();
        win_ready_i = 1'b0;
        check("idle_valid", win_valid_o, 1'b0);
        check("idle_busy", busy_o, 1'b0);
        check("win_persist", win_o, w);
    endtask

    vec_t        vecs [6];
    int          cyc;
    logic [31:0] a0, a7;
    logic [3:0]  be0, be7;
    logic [63:0] w_hold;

    initial begin
        vecs[0] = '{32'h1000_0105, 32'h40, 0, 0, 8, 64'h4645_4406_04C6_C5C4, 17, 1'b0, 32'h1000_00C4, 32'h1000_0146};
        vecs[1] = '{32'h1000_0105, 32'h40, 3, 0, 8, 64'h4645_4406_04C6_C5C4, 41, 1'b0, 32'h1000_00C4, 32'h1000_0146};
        vecs[2] = '{32'h1000_0105, 32'h40, 0, 0, 3, 64'h4645_4406_04C6_C5C4, 17, 1'b1, 32'h1000_00C4, 32'h1000_0146};
        vecs[3] = '{32'h1000_0105, 32'h40, 0, 0, 8, 64'h4645_4406_04C6_C5C4, 17, 1'b0, 32'h1000_00C4, 32'h1000_0146};
        vecs[4] = '{32'h0000_0000, 32'h10, 0, 0, 8, 64'h1110_0F01_FFF1_F0EF, 17, 1'b0, 32'hFFFF_FFEF, 32'h0000_0011};
        vecs[5] = '{32'h1000_0105, 32'h40, 1, 2, 8, 64'h4645_4406_04C6_C5C4, 41, 1'b0, 32'h1000_00C4, 32'h1000_0146};

        rst_ni      = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        stride_i    = '0;
        win_ready_i = 1'b0;
        obi_rsp_i   = '0;
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();
        check("rst_busy", busy_o, 1'b0);
        check("rst_valid", win_valid_o, 1'b0);
        check("rst_win", win_o, 64'h0);
        check("rst_err", err_o, 1'b0);
        check("rst_req", obi_req_o, '0);

        // Directed vectors, memory byte = address low byte.
        foreach (vecs[i]) begin
            run_window(vecs[i].base, vecs[i].stride, vecs[i].gd, vecs[i].rd, vecs[i].ek, 0, cyc, a0, be0, a7, be7);
            check("vec_cycles", 64'(cyc), 64'(vecs[i].exp_cyc));
            check("vec_win", win_o, vecs[i].exp_win);
            check("vec_err", err_o, vecs[i].exp_err);
            check("vec_first_addr", a0, vecs[i].first_pix & ~32'h3);
            check("vec_first_be", be0, 4'b0001 << vecs[i].first_pix[1:0]);
            check("vec_last_addr", a7, vecs[i].last_pix & ~32'h3);
            check("vec_last_be", be7, 4'b0001 << vecs[i].last_pix[1:0]);
            ack(vecs[i].exp_win);
        end

        // Consumer stalls in DONE; a start pulse there must be ignored.
        run_window(32'h2000_0333, 32'h100, 0, 0, 8, 1, cyc, a0, be0, a7, be7);
        w_hold = model_win(32'h2000_0333, 32'h100, 1);
        check("stall_win", win_o, w_hold);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start_i     = 1'b1;
                base_addr_i = 32'h5555_5555;
            end
            tick();
            start_i = 1'b0;
            check("stall_valid", win_valid_o, 1'b1);
            check("stall_win_hold", win_o, w_hold);
            check("stall_busy", busy_o, 1'b1);
            check("stall_no_req", obi_req_o.req, 1'b0);
        end
        ack(w_hold);
        tick();
        check("start_ignored_req", obi_req_o.req, 1'b0);
        check("start_ignored_busy", busy_o, 1'b0);

        // Reset while waiting for the response of read k=4, then a late rvalid.
        start_i     = 1'b1;
        base_addr_i = 32'h1000_0105;
        stride_i    = 32'h40;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 4; k++) serve_read(k, 0, 0, 8, 0, model_pix(32'h1000_0105, 32'h40, k), a0, be0);
        check("k4_req", obi_req_o.req, 1'b1);
        obi_rsp_i.gnt = 1'b1;
        tick();
        obi_rsp_i.gnt = 1'b0;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_win", win_o, 64'h0);
        check("midrst_req", obi_req_o, '0);
        obi_rsp_i.rvalid  = 1'b1;
        obi_rsp_i.r.rdata = 32'hDEAD_BEEF;
        obi_rsp_i.r.err   = 1'b1;
        tick();
        obi_rsp_i = '0;
        check("late_rvalid_busy", busy_o, 1'b0);
        check("late_rvalid_valid", win_valid_o, 1'b0);
        check("late_rvalid_win", win_o, 64'h0);
        check("late_rvalid_err", err_o, 1'b0);
        run_window(32'h1000_0105, 32'h40, 0, 0, 8, 0, cyc, a0, be0, a7, be7);
        check("postrst_win", win_o, 64'h4645_4406_04C6_C5C4);
        check("postrst_cycles", 64'(cyc), 64'd17);
        ack(64'h4645_4406_04C6_C5C4);

        // Random windows against the reference model.
        for (int n = 0; n < 20; n++) begin
            logic [31:0] b, s;
            int gd, rd, ek;
            b  = $urandom;
            s  = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 4096));
            gd = $urandom_range(0, 3);
            rd = $urandom_range(0, 3);
            ek = $urandom_range(0, 8);
            run_window(b, s, gd, rd, ek, 1, cyc, a0, be0, a7, be7);
            check("rnd_win", win_o, model_win(b, s, 1));
            check("rnd_err", err_o, ek < 8);
            check("rnd_cycles", 64'(cyc), 64'(1 + 8 * (gd + rd + 2)));
            ack(model_win(b, s, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
